// File: rtl/otp_xor_buffer.sv
// Banked raw/one-time-pad store returning raw^otp, with fill tracking and single-use pads.
// Optional pad scrubbing after consumption: define OTP_XOR_BUFFER_ZEROIZE_EN.
module otp_xor_buffer #(
   parameter int NUM_BANKS = 8,
   parameter int DATA_W    = 4,
   parameter int DEPTH     = 1024,
   parameter int BANK_W    = $clog2(NUM_BANKS),
   parameter int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                 iclk,
   input  logic                 irst_n,
   input  logic                 iotp_we,
   input  logic [BANK_W-1:0]    iotp_bank,
   input  logic [ADDR_W-1:0]    iotp_addr,
   input  logic [DATA_W-1:0]    iotp_wdata,
   input  logic                 iraw_we,
   input  logic [BANK_W-1:0]    iraw_bank,
   input  logic [ADDR_W-1:0]    iraw_addr,
   input  logic [DATA_W-1:0]    iraw_wdata,
   input  logic                 ird_req,
   input  logic [BANK_W-1:0]    ird_bank,
   input  logic [ADDR_W-1:0]    ird_addr,
   input  logic                 ird_last,
   output logic [DATA_W-1:0]    ordata,
   output logic                 ordata_valid,
   output logic [NUM_BANKS-1:0] ootp_full,
   output logic [NUM_BANKS-1:0] oraw_full,
   output logic [NUM_BANKS-1:0] obusy,
   output logic                 oerr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [NUM_BANKS-1:0] otp_full_q, raw_full_q, busy;
   logic [NUM_BANKS-1:0] otp_wr_vec, raw_wr_vec, rd_sel_vec, consume_vec;
   logic                 otp_wr_ok, raw_wr_ok, rd_ok;
   logic                 vld_p1, seen_p1, err_q;
   logic [BANK_W-1:0]    rd_bank_p1;
   logic [NUM_BANKS-1:0][DATA_W-1:0] bank_xor;

   // Stage p0: accept decisions use the flags as they stand before this edge
   assign otp_wr_ok   = iotp_we & ~otp_full_q[iotp_bank] & ~busy[iotp_bank];
   assign raw_wr_ok   = iraw_we & ~raw_full_q[iraw_bank] & ~busy[iraw_bank];
   assign rd_ok       = ird_req & otp_full_q[ird_bank] & raw_full_q[ird_bank] & ~busy[ird_bank];
   assign otp_wr_vec  = otp_wr_ok ? (NUM_BANKS'(1) << iotp_bank) : '0;
   assign raw_wr_vec  = raw_wr_ok ? (NUM_BANKS'(1) << iraw_bank) : '0;
   assign rd_sel_vec  = rd_ok ? (NUM_BANKS'(1) << ird_bank) : '0;
   assign consume_vec = ird_last ? rd_sel_vec : '0;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         otp_full_q <= '0;
         raw_full_q <= '0;
         err_q      <= 1'b0;
         vld_p1     <= 1'b0;
         seen_p1    <= 1'b0;
      end else begin
         otp_full_q <= (otp_full_q | ((iotp_addr == LAST_ADDR) ? otp_wr_vec : '0)) & ~consume_vec;
         raw_full_q <= (raw_full_q | ((iraw_addr == LAST_ADDR) ? raw_wr_vec : '0)) & ~consume_vec;
         err_q      <= err_q | (iotp_we & ~otp_wr_ok) | (iraw_we & ~raw_wr_ok) | (ird_req & ~rd_ok);
         vld_p1     <= rd_ok;
         seen_p1    <= seen_p1 | rd_ok;
      end
   end

   always_ff @(posedge iclk) begin
      if (rd_ok) rd_bank_p1 <= ird_bank;
   end

`ifdef OTP_XOR_BUFFER_ZEROIZE_EN
   typedef enum logic {S_IDLE, S_SCRUB} state_t;
   state_t               state_q, state_d;
   logic [BANK_W-1:0]    scrub_bank_q, scrub_bank_d, pick_idx;
   logic [ADDR_W-1:0]    scrub_cnt_q, scrub_cnt_d;
   logic [NUM_BANKS-1:0] pend_q, pend_d, cand;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q      <= S_IDLE;
         scrub_bank_q <= '0;
         scrub_cnt_q  <= '0;
         pend_q       <= '0;
      end else begin
         state_q      <= state_d;
         scrub_bank_q <= scrub_bank_d;
         scrub_cnt_q  <= scrub_cnt_d;
         pend_q       <= pend_d;
      end
   end

   // Consumes arriving this cycle join the pending mask; lowest bank starts first
   always_comb begin
      cand         = pend_q | consume_vec;
      pick_idx     = '0;
      state_d      = state_q;
      scrub_bank_d = scrub_bank_q;
      scrub_cnt_d  = scrub_cnt_q;
      pend_d       = cand;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         if (cand[i]) pick_idx = BANK_W'(i);
      end
      if (state_q == S_SCRUB) scrub_cnt_d = scrub_cnt_q + 1'b1;
      if (state_q == S_IDLE || scrub_cnt_q == LAST_ADDR) begin
         if (|cand) begin
            state_d      = S_SCRUB;
            scrub_bank_d = pick_idx;
            scrub_cnt_d  = '0;
            pend_d       = cand & ~(NUM_BANKS'(1) << pick_idx);
         end else begin
            state_d      = S_IDLE;
         end
      end
   end

   assign busy = (state_q == S_SCRUB) ? (NUM_BANKS'(1) << scrub_bank_q) : '0;
`else
   assign busy = '0;
`endif

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [DATA_W-1:0] raw_mem [DEPTH];
      logic [DATA_W-1:0] otp_mem [DEPTH];
      logic [DATA_W-1:0] raw_rd_p1, otp_rd_p1;
      logic              otp_we;
      logic [ADDR_W-1:0] otp_waddr;
      logic [DATA_W-1:0] otp_wdata;
`ifdef OTP_XOR_BUFFER_ZEROIZE_EN
      // A busy bank rejects pad writes, so the scrub never contends with an accepted one
      logic scrub_hit;
      assign scrub_hit = (state_q == S_SCRUB) && (scrub_bank_q == BANK_W'(g));
      assign otp_we    = scrub_hit | otp_wr_vec[g];
      assign otp_waddr = scrub_hit ? scrub_cnt_q : iotp_addr;
      assign otp_wdata = scrub_hit ? '0 : iotp_wdata;
`else
      assign otp_we    = otp_wr_vec[g];
      assign otp_waddr = iotp_addr;
      assign otp_wdata = iotp_wdata;
`endif
      always_ff @(posedge iclk) begin
         if (raw_wr_vec[g]) raw_mem[iraw_addr] <= iraw_wdata;
         if (otp_we)        otp_mem[otp_waddr] <= otp_wdata;
         if (rd_sel_vec[g]) begin
            raw_rd_p1 <= raw_mem[ird_addr];
            otp_rd_p1 <= otp_mem[ird_addr];
         end
      end
      assign bank_xor[g] = raw_rd_p1 ^ otp_rd_p1;
   end

   // Stage p1: read registers only move on an accepted read, so ordata holds otherwise
   assign ordata       = seen_p1 ? bank_xor[rd_bank_p1] : '0;
   assign ordata_valid = vld_p1;
   assign ootp_full    = otp_full_q;
   assign oraw_full    = raw_full_q;
   assign obusy        = busy;
   assign oerr         = err_q;

endmodule
